mem_port_sequencer: RTL and testbench

//  Shares the single byte-lane data memory port between instruction fetch and load/store.

---
 rtl/mem_seq_pkg.sv | 26 ++
 rtl/mem_lane_fmt.sv | 40 ++++
 rtl/mem_port_sequencer.sv | 137 +++++++++++++
 tb/tb_mem_port_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types for the memory port sequencer: FSM states, owners, funct3 codes and byte lanes.
package mem_seq_pkg;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    typedef enum logic {OWN_FETCH, OWN_LS} owner_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Lane k carries byte address offset k (little-endian word bits [8k+7:8k]).
    typedef logic [0:3][7:0] byte_lanes_t;

    function automatic logic [31:0] lanes_to_word(input byte_lanes_t l);
        return {l[3], l[2], l[1], l[0]};
    endfunction

    function automatic byte_lanes_t word_to_lanes(input logic [31:0] w);
        byte_lanes_t l;
        for (int k = 0; k < 4; k++) l[k] = w[8*k +: 8];
        return l;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane formatter: store merge into an old word and load extract/extend.
module mem_lane_fmt
    import mem_seq_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  byte_lanes_t old_lanes_i,
    input  logic [31:0] wdata_i,
    input  byte_lanes_t rd_lanes_i,
    output byte_lanes_t merged_o,
    output logic [31:0] load_word_o
);

    logic [31:0] shifted;

    // Sub-word stores replace only the addressed lanes; anything else is a full word.
    always_comb begin
        merged_o = old_lanes_i;
        case (funct3_i)
            F3_B: merged_o[offset_i] = wdata_i[7:0];
            F3_H: begin
                merged_o[offset_i]           = wdata_i[7:0];
                merged_o[2'(offset_i + 2'd1)] = wdata_i[15:8];
            end
            default: merged_o = word_to_lanes(wdata_i);
        endcase
    end

    always_comb begin
        shifted = lanes_to_word(rd_lanes_i) >> {offset_i, 3'b000};
        case (funct3_i)
            F3_B:    load_word_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_word_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_word_o = {24'd0, shifted[7:0]};
            F3_HU:   load_word_o = {16'd0, shifted[15:0]};
            default: load_word_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_port_sequencer.sv
// Arbitrates fetch and load/store onto one byte-lane memory port, one multi-cycle
// transaction at a time, with read-modify-write for sub-word stores.
module mem_port_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter bit          DATA_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [2:0]        ls_funct3,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_gnt,
    output logic              ls_valid,
    output logic [31:0]       ls_rdata,
    output logic              ls_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output byte_lanes_t       mem_data_in,
    input  byte_lanes_t       mem_data_out
);

    state_t            state_q, state_d;
    owner_t            owner_q;
    logic              ptr_q;
    logic              we_q, err_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q;
    byte_lanes_t       old_q;

    logic              grant_ls, grant_if, req_err, done, busy;
    byte_lanes_t       merged;
    logic [31:0]       load_word;

    // ptr_q = 1 gives load/store the tie; it moves to the loser on every grant.
    assign grant_ls = (state_q == IDLE) && ls_req && (!if_req || ptr_q);
    assign grant_if = (state_q == IDLE) && if_req && !grant_ls;
    assign ls_gnt   = grant_ls;
    assign if_gnt   = grant_if;

    always_comb begin
        req_err = 1'b0;
        if (grant_ls) begin
            case (ls_funct3)
                F3_B:    req_err = 1'b0;
                F3_BU:   req_err = ls_we;
                F3_H:    req_err = ls_addr[0];
                F3_HU:   req_err = ls_we || ls_addr[0];
                F3_W:    req_err = (ls_addr[1:0] != 2'b00);
                default: req_err = 1'b1;
            endcase
        end else begin
            req_err = (if_addr[1:0] != 2'b00);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_ls || grant_if) begin
                    if (req_err)                                   state_d = DONE;
                    else if (grant_ls && ls_we && ls_funct3 == F3_W) state_d = WRITE;
                    else                                           state_d = READ;
                end
            end
            READ:    state_d = (owner_q == OWN_LS && we_q) ? WRITE : DONE;
            WRITE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_FETCH;
            ptr_q   <= DATA_FIRST;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant_ls || grant_if) begin
                owner_q <= grant_ls ? OWN_LS : OWN_FETCH;
                ptr_q   <= !grant_ls;
                we_q    <= grant_ls && ls_we;
                f3_q    <= grant_ls ? ls_funct3 : F3_W;
                addr_q  <= grant_ls ? ls_addr : if_addr;
                wdata_q <= ls_wdata;
                err_q   <= req_err;
                rdata_q <= '0;
            end
            if (state_q == READ) begin
                old_q <= mem_data_out;
                if (!we_q) rdata_q <= load_word;
            end
        end
    end

    mem_lane_fmt u_fmt (
        .funct3_i    (f3_q),
        .offset_i    (addr_q[1:0]),
        .old_lanes_i (old_q),
        .wdata_i     (wdata_q),
        .rd_lanes_i  (mem_data_out),
        .merged_o    (merged),
        .load_word_o (load_word)
    );

    assign busy         = (state_q == READ) || (state_q == WRITE);
    assign done         = (state_q == DONE);
    assign mem_addr     = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_write_en = (state_q == WRITE);
    assign mem_data_in  = busy ? merged : '0;

    assign ls_valid = done && (owner_q == OWN_LS);
    assign ls_err   = ls_valid && err_q;
    assign ls_rdata = ls_valid ? rdata_q : '0;
    assign if_valid = done && (owner_q == OWN_FETCH);
    assign if_err   = if_valid && err_q;
    assign if_rdata = if_valid ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer with a small word-array memory behind the port.
module tb_mem_port_sequencer;
    import mem_seq_pkg::*;

    localparam int unsigned ADDR_W = 32;

    logic              clk, rst;
    logic              if_req, if_gnt, if_valid, if_err;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              ls_req, ls_we, ls_gnt, ls_valid, ls_err;
    logic [2:0]        ls_funct3;
    logic [ADDR_W-1:0] ls_addr, mem_addr;
    logic [31:0]       ls_wdata, ls_rdata;
    logic              mem_write_en;
    byte_lanes_t       mem_data_in, mem_data_out;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_sequencer #(.ADDR_W(ADDR_W), .DATA_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
        .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
        .ls_err(ls_err),
        .mem_addr(mem_addr), .mem_write_en(mem_write_en),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, write committed at the rising edge; bench preloads go through here.
    logic [31:0] mem [256];
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;
    logic [31:0] mem_rd_word;

    assign mem_rd_word  = mem[mem_addr[9:2]];
    assign mem_data_out = word_to_lanes(mem_rd_word);

    always @(posedge clk) begin
        if (pre_en)            mem[pre_idx] <= pre_val;
        else if (mem_write_en) mem[mem_addr[9:2]] <= lanes_to_word(mem_data_in);
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_mem;
        logic        exp_we;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic run_ls(input int id, input vec_t v);
        int   lat;
        logic got, saw_we;
        preload(v.addr[9:2], v.init);
        @(negedge clk);
        ls_req = 1'b1; ls_we = v.we; ls_funct3 = v.f3; ls_addr = v.addr; ls_wdata = v.wdata;
        #1 check($sformatf("v%0d ls_gnt", id), 32'(ls_gnt), 32'd1);
        @(posedge clk);
        #1 ls_req = 1'b0;
        lat = 0; got = 1'b0; saw_we = 1'b0;
        for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clk);
            saw_we |= mem_write_en;
            if (c == 1 && !v.exp_err)
                check($sformatf("v%0d mem_addr", id), mem_addr, v.addr & ~32'd3);
            if (ls_valid) begin
                got = 1'b1;
                lat = c;
                check($sformatf("v%0d ls_rdata", id), ls_rdata, v.exp_rdata);
                check($sformatf("v%0d ls_err", id), 32'(ls_err), 32'(v.exp_err));
            end
        end
        check($sformatf("v%0d latency", id), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d write_en seen", id), 32'(saw_we), 32'(v.exp_we));
        @(negedge clk);
        check($sformatf("v%0d mem word", id), mem[v.addr[9:2]], v.exp_mem);
    endtask

    task automatic run_if(input string name, input logic [31:0] addr, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat);
        int   lat;
        logic got, saw_ls;
        @(negedge clk);
        if_req = 1'b1; if_addr = addr;
        #1 check({name, " if_gnt"}, 32'(if_gnt), 32'd1);
        @(posedge clk);
        #1 if_req = 1'b0;
        lat = 0; got = 1'b0; saw_ls = 1'b0;
        for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clk);
            saw_ls |= ls_valid;
            if (if_valid) begin
                got = 1'b1;
                lat = c;
                check({name, " if_rdata"}, if_rdata, exp_rdata);
                check({name, " if_err"}, 32'(if_err), 32'(exp_err));
            end
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " no ls_valid"}, 32'(saw_ls), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] seq;
        int         n;
        logic       both, saw_v;

        rst = 1'b1; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_funct3 = '0; ls_addr = '0; ls_wdata = '0;

        //                 we    f3     addr       wdata         init          rdata         err  lat mem           we
        vecs[0]  = '{1'b0, F3_W,  32'h100, 32'h0,        32'h8899AABB, 32'h8899AABB, 1'b0, 2, 32'h8899AABB, 1'b0};
        vecs[1]  = '{1'b0, F3_B,  32'h103, 32'h0,        32'h80000000, 32'hFFFFFF80, 1'b0, 2, 32'h80000000, 1'b0};
        vecs[2]  = '{1'b0, F3_BU, 32'h107, 32'h0,        32'h80000000, 32'h00000080, 1'b0, 2, 32'h80000000, 1'b0};
        vecs[3]  = '{1'b0, F3_H,  32'h10A, 32'h0,        32'h80011234, 32'hFFFF8001, 1'b0, 2, 32'h80011234, 1'b0};
        vecs[4]  = '{1'b0, F3_HU, 32'h110, 32'h0,        32'hAAAAF00D, 32'h0000F00D, 1'b0, 2, 32'hAAAAF00D, 1'b0};
        vecs[5]  = '{1'b0, F3_B,  32'h111, 32'h0,        32'h00007F00, 32'h0000007F, 1'b0, 2, 32'h00007F00, 1'b0};
        vecs[6]  = '{1'b1, F3_B,  32'h102, 32'h00000055, 32'h11223344, 32'h0,        1'b0, 3, 32'h11553344, 1'b1};
        vecs[7]  = '{1'b1, F3_H,  32'h116, 32'h0000CAFE, 32'h11223344, 32'h0,        1'b0, 3, 32'hCAFE3344, 1'b1};
        vecs[8]  = '{1'b1, F3_W,  32'h118, 32'hDEADBEEF, 32'h00000000, 32'h0,        1'b0, 2, 32'hDEADBEEF, 1'b1};
        vecs[9]  = '{1'b1, F3_H,  32'h101, 32'h0000BEEF, 32'h11223344, 32'h0,        1'b1, 1, 32'h11223344, 1'b0};
        vecs[10] = '{1'b0, F3_W,  32'h102, 32'h0,        32'h55667788, 32'h0,        1'b1, 1, 32'h55667788, 1'b0};
        vecs[11] = '{1'b1, 3'd4,  32'h120, 32'h000000AA, 32'h01020304, 32'h0,        1'b1, 1, 32'h01020304, 1'b0};
        vecs[12] = '{1'b0, 3'd3,  32'h124, 32'h0,        32'h01020304, 32'h0,        1'b1, 1, 32'h01020304, 1'b0};
        vecs[13] = '{1'b0, F3_H,  32'h125, 32'h0,        32'h01020304, 32'h0,        1'b1, 1, 32'h01020304, 1'b0};

        // Outputs while reset is held.
        #3;
        check("rst if_valid", 32'(if_valid), 32'd0);
        check("rst ls_valid", 32'(ls_valid), 32'd0);
        check("rst mem_write_en", 32'(mem_write_en), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst ls_rdata", ls_rdata, 32'd0);
        check("rst if_rdata", if_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Both requesters held from reset: alternate grants starting with load/store.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h200;
        ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = F3_W; ls_addr = 32'h204;
        seq = '0; n = 0; both = 1'b0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            #1;
            if (ls_gnt && if_gnt) both = 1'b1;
            if (ls_gnt) begin seq[n] = 1'b1; n++; end
            else if (if_gnt) begin seq[n] = 1'b0; n++; end
            @(negedge clk);
        end
        if_req = 1'b0; ls_req = 1'b0;
        check("arb grant count", 32'(n), 32'd4);
        check("arb order LS,IF,LS,IF", 32'(seq), 32'(4'b0101));
        check("arb no double grant", 32'(both), 32'd0);
        repeat (4) @(negedge clk);

        preload(8'h80, 32'hCAFEF00D);
        run_if("fetch aligned", 32'h200, 32'hCAFEF00D, 1'b0, 2);
        run_if("fetch misaligned", 32'h202, 32'h0, 1'b1, 1);

        for (int i = 0; i < 14; i++) run_ls(i, vecs[i]);

        // Async reset in the WRITE cycle of a sub-word store.
        preload(8'h4C, 32'h11223344);
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = F3_B; ls_addr = 32'h131; ls_wdata = 32'h000000AA;
        #1 check("rmw-rst ls_gnt", 32'(ls_gnt), 32'd1);
        @(posedge clk);
        #1 ls_req = 1'b0;
        @(posedge clk);
        #2 check("rmw-rst write_en before reset", 32'(mem_write_en), 32'd1);
        rst = 1'b1;
        #1 check("rmw-rst write_en drops", 32'(mem_write_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_v = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            saw_v |= ls_valid | if_valid;
        end
        check("rmw-rst no valid", 32'(saw_v), 32'd0);
        check("rmw-rst mem untouched", mem[8'h4C], 32'h11223344);
        if_req = 1'b1; if_addr = 32'h200;
        ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = F3_W; ls_addr = 32'h100;
        #1;
        check("rmw-rst first ls_gnt", 32'(ls_gnt), 32'd1);
        check("rmw-rst first if_gnt", 32'(if_gnt), 32'd0);
        @(posedge clk);
        #1 if_req = 1'b0; ls_req = 1'b0;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
